// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state encoding, arctangent table and quadrant-fold thresholds.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_DONE
  } cordic_state_e;

  localparam int MAX_ITERATIONS = 16;
  localparam int SHIFT_W        = 4;
  localparam int ATAN_REF_WIDTH = 16;

  // atan(2^-i) at the reference scale where 2^ATAN_REF_WIDTH represents pi.
  function automatic int atan_ref(input int i);
    case (i)
      0:       return 16384;
      1:       return 9672;
      2:       return 5110;
      3:       return 2594;
      4:       return 1302;
      5:       return 652;
      6:       return 326;
      7:       return 163;
      8:       return 81;
      9:       return 41;
      10:      return 20;
      11:      return 10;
      12:      return 5;
      13:      return 3;
      14:      return 1;
      default: return 1;
    endcase
  endfunction

  // Narrower angle widths round the reference entry; wider ones scale it up.
  function automatic int atan_entry(input int i, input int aw);
    if (aw >= ATAN_REF_WIDTH)
      return atan_ref(i) << (aw - ATAN_REF_WIDTH);
    else
      return (atan_ref(i) + (1 << (ATAN_REF_WIDTH - 1 - aw))) >> (ATAN_REF_WIDTH - aw);
  endfunction

  // Angles at or beyond +/- pi/2 are folded by a half turn before rotating.
  function automatic int fold_thr(input int aw);
    return 1 << (aw - 1);
  endfunction

endpackage

// File: rtl/cordic_stage_var.sv
// One combinational CORDIC micro-rotation with a runtime shift amount and arctangent step.
module cordic_stage_var
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int ANGLE_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH:0]  x_i,
  input  logic signed [DATA_WIDTH:0]  y_i,
  input  logic signed [ANGLE_WIDTH:0] z_i,
  input  logic signed [ANGLE_WIDTH:0] atan_i,
  input  logic        [SHIFT_W-1:0]   shift_i,
  output logic signed [DATA_WIDTH:0]  x_o,
  output logic signed [DATA_WIDTH:0]  y_o,
  output logic signed [ANGLE_WIDTH:0] z_o
);

  logic signed [DATA_WIDTH:0] x_sh;
  logic signed [DATA_WIDTH:0] y_sh;
  logic                       rot_pos;

  assign x_sh    = x_i >>> shift_i;
  assign y_sh    = y_i >>> shift_i;
  assign rot_pos = !z_i[ANGLE_WIDTH] && (z_i != '0);

  always_comb begin
    if (rot_pos) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_seq.sv
// Iterative rotation-mode CORDIC: one micro-rotation per cycle with a valid/ready handshake
// on both sides; results carry the CORDIC gain.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_WIDTH:0]  x_in,
  input  logic signed [DATA_WIDTH:0]  y_in,
  input  logic signed [ANGLE_WIDTH:0] z_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_WIDTH:0]  x_out,
  output logic signed [DATA_WIDTH:0]  y_out,
  output logic signed [ANGLE_WIDTH:0] z_out,
  output logic                        busy
);

  localparam logic signed [ANGLE_WIDTH:0] FOLD_HI = (ANGLE_WIDTH+1)'(fold_thr(ANGLE_WIDTH));
  localparam logic signed [ANGLE_WIDTH:0] FOLD_LO = -FOLD_HI;
  localparam logic        [ANGLE_WIDTH:0] TURN    = {1'b1, {ANGLE_WIDTH{1'b0}}};
  localparam logic        [SHIFT_W-1:0]   I_LAST  = SHIFT_W'(ITERATIONS - 1);

  cordic_state_e              state_q;
  logic [SHIFT_W-1:0]         i_q;
  logic                       neg_q;
  logic signed [DATA_WIDTH:0] x_q, y_q, x_out_q, y_out_q;
  logic signed [ANGLE_WIDTH:0] z_q, z_out_q;

  logic signed [DATA_WIDTH:0]  x_d, y_d;
  logic signed [ANGLE_WIDTH:0] z_d, z_fold_d, atan_d;
  logic                        neg_fold_d;

  always_comb begin
    z_fold_d   = z_in;
    neg_fold_d = 1'b0;
    if (z_in >= FOLD_HI) begin
      z_fold_d   = z_in - TURN;
      neg_fold_d = 1'b1;
    end else if (z_in < FOLD_LO) begin
      z_fold_d   = z_in + TURN;
      neg_fold_d = 1'b1;
    end
  end

  assign atan_d = (ANGLE_WIDTH+1)'(atan_entry(int'(i_q), ANGLE_WIDTH));

  cordic_stage_var #(
    .DATA_WIDTH (DATA_WIDTH),
    .ANGLE_WIDTH(ANGLE_WIDTH)
  ) u_stage (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .atan_i (atan_d),
    .shift_i(i_q),
    .x_o    (x_d),
    .y_o    (y_d),
    .z_o    (z_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      neg_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q     <= x_in;
            y_q     <= y_in;
            z_q     <= z_fold_d;
            neg_q   <= neg_fold_d;
            i_q     <= '0;
            state_q <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 1'b1;
          if (i_q == I_LAST) begin
            // A folded angle rotated the opposite half-plane; negation restores it.
            x_out_q <= neg_q ? -x_d : x_d;
            y_out_q <= neg_q ? -y_d : y_d;
            z_out_q <= z_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;

endmodule

// File: doc/cordic_seq.md
CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 12; x/y are signed DATA_WIDTH+1 bits.
REQ-002 Parameter ANGLE_WIDTH, default 16; z is signed ANGLE_WIDTH+1 bits, full scale [-2^ANGLE_WIDTH, 2^ANGLE_WIDTH) = [-pi, pi).
REQ-003 Parameter ITERATIONS, default 12, range 1..16; micro-rotations per operation.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  operand valid; in_ready  out  1  block can accept.
REQ-008 x_in, y_in  in  DATA_WIDTH+1  signed start vector; z_in  in  ANGLE_WIDTH+1  signed rotation angle.
REQ-009 out_valid  out  1  result valid; out_ready  in  1  consumer accepts.
REQ-010 x_out, y_out  out  DATA_WIDTH+1  signed rotated vector, unscaled (CORDIC gain included); z_out  out  ANGLE_WIDTH+1  residual angle.
REQ-011 busy  out  1  high in ROTATE or DONE.

Function
REQ-012 FSM states IDLE, ROTATE, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 IDLE: on in_valid, register operands, apply the quadrant fold, clear iteration counter i, go to ROTATE.
REQ-014 Fold: z_in >= 2^(ANGLE_WIDTH-1) -> z = z_in - 2^ANGLE_WIDTH, neg = 1; z_in < -2^(ANGLE_WIDTH-1) -> z = z_in + 2^ANGLE_WIDTH, neg = 1; otherwise z = z_in, neg = 0.
REQ-015 ROTATE, once per cycle: z > 0 -> x -= y>>>i, y += x>>>i, z -= atan[i]; z <= 0 -> x += y>>>i, y -= x>>>i, z += atan[i]; all updates use pre-update values.
REQ-016 Shifts are arithmetic. Add, subtract and shift wrap modulo the register width, with no saturation.
REQ-017 Counter i runs from 0 to ITERATIONS-1. After the update with i = ITERATIONS-1, go to DONE.
REQ-018 On entry to DONE: x_out/y_out = neg ? -x : x (-y : y), two's complement wrap; z_out = z.
REQ-019 DONE: outputs held stable until out_ready; on out_valid & out_ready go to IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-020 Latency: input accepted at edge 0; out_valid high after edge ITERATIONS+1; throughput one operation per ITERATIONS+2 cycles minimum.
REQ-021 in_valid outside IDLE is ignored; operand registers change only on an IDLE accept.
REQ-022 atan[i] = round(atan(2^-i) * 2^ANGLE_WIDTH / pi); for ANGLE_WIDTH=16: 16384, 9672, 5110, 2594, 1302, 652, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1.

Reset
REQ-023 rst forces state IDLE, i = 0, neg = 0; x_out, y_out, z_out, internal x/y/z = 0; out_valid = 0, busy = 0, in_ready = 1 the cycle after reset.
REQ-024 rst mid-ROTATE or mid-DONE aborts the operation; no out_valid is produced for it.
REQ-025 rst has priority over every handshake in the same cycle.

Structure
REQ-026 Shared package cordic_pkg holds the atan table function/constant (parameterised by ANGLE_WIDTH), the FSM state enum and the fold thresholds.
REQ-027 One sub-module, cordic_stage_var: combinational micro-rotation with runtime shift amount i and atan input. The FSM, counter and registers stay in cordic_seq.

Verification
REQ-028 x=1000, y=0, z=0 -> after ITERATIONS+1 cycles x_out ~ 1646 (+/-3), y_out ~ 0 (+/-3), z_out within +/-2 LSB of 0.
REQ-029 x=1000, y=0, z=16384 (pi/4) -> x_out ~ y_out ~ 1164 (+/-3).
REQ-030 x=1000, y=0, z=32768 (pi/2 fold boundary, neg=1) -> x_out ~ 0, y_out ~ 1646; z=-65536 (-pi) -> x_out ~ -1646, y_out ~ 0.
REQ-031 Back-pressure: out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid ignored; after out_ready pulse, the next accept occurs one cycle later.
REQ-032 rst asserted at iteration 4 -> next cycle IDLE, outputs 0, in_ready=1, no out_valid; a following operation completes correctly.
REQ-033 Back-to-back random angles against a reference model, 1000 ops -> every result within +/-3 LSB, exactly one out_valid per accepted input.
